hll_layer_accumulator: RTL and testbench
========================================

// Module: hll_layer_accumulator
// PURPOSE
// Upstream feeder for the 3D entanglement cell. Consumes a stream of {layer, hash}
// tokens, folds each hash into a per-layer HASH_WIDTH-bit register (HLL rank bit),
// and on a snapshot request publishes the frozen set of layer registers as
// layer_registers, then starts a fresh epoch. Output bus drives the cell directly.
// PARAMETERS
// NUM_LAYERS  8   number of layers (z-planes); in_layer width LW = $clog2(NUM_LAYERS)
// HASH_WIDTH  64  hash width = bits per layer register; rank width RW = $clog2(HASH_WIDTH)
// CNT_WIDTH   32  width of item/drop counters
// PORTS
// clk              in   1                      system clock, rising edge
// reset_n          in   1                      asynchronous, active-low reset
// in_valid         in   1                      token valid
// in_ready         out  1                      token accepted when in_valid & in_ready
// in_layer         in   LW                     target layer index
// in_hash          in   HASH_WIDTH             hashed item
// snap_req         in   1                      level; request publish of current epoch
// snap_ack         out  1                      1-cycle pulse: snapshot published
// layer_registers  out  [NUM_LAYERS][HASH_WIDTH] published registers (packed 2-D)
// regs_valid       out  1                      1-cycle pulse coincident with new layer_registers
// epoch            out  16                     published-epoch count, wraps 0xFFFF->0
// item_count       out  CNT_WIDTH              tokens folded in the published epoch (saturating)
// drop_count       out  CNT_WIDTH              tokens dropped (in_layer>=NUM_LAYERS), cumulative, saturating
// BEHAVIOUR
// - Reset: all outputs 0 except in_ready=0; working registers 0; state ACCUM. in_ready
//   goes high the first cycle after reset_n deasserts.
// - Rank: r = trailing-zero count of in_hash; in_hash==0 -> r = HASH_WIDTH-1; r clamped to HASH_WIDTH-1.
// - Pipeline, 2 stages: S1 registers accepted token; S2 computes r and ORs (1<<r) into
//   work[in_layer], increments epoch item counter (saturating). Invalid layer: no OR, drop_count++.
// - FSM: ACCUM -> FLUSH -> PUBLISH -> ACCUM.
//   ACCUM: in_ready = !snap_req. snap_req=1 at cycle T -> FLUSH at T+1 (no token accepted at T).
//   FLUSH: in_ready=0; stays until S1,S2 empty (exactly 2 cycles: T+1,T+2).
//   PUBLISH (T+3): layer_registers<=work, item_count<=epoch items, epoch++, then work<=0 and
//   epoch items<=0 in same cycle. T+4: regs_valid=1, snap_ack=1 (one cycle), state ACCUM, in_ready=!snap_req.
// - snap_req still high at T+4 starts a new snapshot (empty epoch allowed: publishes zeros).
// - layer_registers/item_count/epoch hold stable between publishes.
// - Same layer, back-to-back tokens: S2 OR is read-modify-write on work; consecutive
//   updates to same layer must both land (bypass not needed: single-writer per cycle).
// - reset_n asserted mid-FLUSH/PUBLISH: in-flight tokens and epoch discarded; all to reset values.
// - drop_count is not cleared by snapshot; only by reset.
// STRUCTURE
// - Shared package hll_pkg: state enum {ACCUM, FLUSH, PUBLISH}; function tz_rank(hash) -> RW bits;
//   localparams LW, RW derived from NUM_LAYERS/HASH_WIDTH.
// - One sub-module: hll_tz_encode (combinational trailing-zero encoder with zero/clamp rule),
//   instanced in S2. Everything else flat in this module.
// TESTING
// - Reset: hold reset_n=0 3 cycles -> layer_registers=0, regs_valid=0, epoch=0, in_ready=0; high 1 cycle later.
// - Fold: layer 2 hashes 0x1, 0x8, 0x0 then snap_req -> layer_registers[2]=0x8000_0000_0000_0009,
//   others 0, item_count=3, epoch=1, regs_valid exactly at T+4.
// - Drop: in_layer=NUM_LAYERS (8, LW=3 -> use NUM_LAYERS=6, layer 7) -> drop_count=1, registers unchanged.
// - Snapshot contention: in_valid=1 held with snap_req=1 -> no accept from T to T+3; token accepted at T+4
//   lands in next epoch only.
// - Empty epoch: two snapshots back-to-back with no tokens -> second publish all zeros, item_count=0, epoch=2.
// - Reset mid-FLUSH: 5 tokens in, snap_req, reset_n=0 at T+2 -> no regs_valid pulse, all outputs 0.

Source files
------------

// File: rtl/hll_pkg.sv
// Shared types and helpers for the HLL layer accumulator.
// Holds the FSM state encoding, default sizing and a reference rank function.
package hll_pkg;

    localparam int HLL_NUM_LAYERS = 8;
    localparam int HLL_HASH_WIDTH = 64;
    localparam int LW             = $clog2(HLL_NUM_LAYERS);
    localparam int RW             = $clog2(HLL_HASH_WIDTH);

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        FLUSH   = 2'd1,
        PUBLISH = 2'd2
    } hll_state_t;

    // Trailing-zero rank of a default-width hash; an all-zero hash maps to the top bit.
    function automatic logic [RW-1:0] tz_rank(input logic [HLL_HASH_WIDTH-1:0] hash);
        logic [RW-1:0] r;
        r = RW'(HLL_HASH_WIDTH - 1);
        for (int i = HLL_HASH_WIDTH - 1; i >= 0; i--) begin
            if (hash[i]) begin
                r = RW'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/hll_tz_encode.sv
// Combinational trailing-zero encoder used by the fold stage.
// A zero hash has no set bit, so it is given the highest rank the register can hold.
module hll_tz_encode #(
    parameter int HASH_WIDTH = 64,
    localparam int RANK_W    = $clog2(HASH_WIDTH)
) (
    input  logic [HASH_WIDTH-1:0] hash,
    output logic [RANK_W-1:0]     rank
);

    // Scan from the top down so the lowest set bit is the last one to win.
    always_comb begin
        rank = RANK_W'(HASH_WIDTH - 1);
        for (int i = HASH_WIDTH - 1; i >= 0; i--) begin
            if (hash[i]) begin
                rank = RANK_W'(i);
            end
        end
    end

endmodule

// File: rtl/hll_layer_accumulator.sv
// Folds a {layer, hash} token stream into per-layer HLL rank registers and
// publishes the frozen set on request, starting a fresh epoch each time.
module hll_layer_accumulator
    import hll_pkg::*;
#(
    parameter int NUM_LAYERS = 8,
    parameter int HASH_WIDTH = 64,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [$clog2(NUM_LAYERS)-1:0]         in_layer,
    input  logic [HASH_WIDTH-1:0]                 in_hash,
    input  logic                                  snap_req,
    output logic                                  snap_ack,
    output logic [NUM_LAYERS-1:0][HASH_WIDTH-1:0] layer_registers,
    output logic                                  regs_valid,
    output logic [15:0]                           epoch,
    output logic [CNT_WIDTH-1:0]                  item_count,
    output logic [CNT_WIDTH-1:0]                  drop_count
);

    localparam int LAYER_W = $clog2(NUM_LAYERS);
    localparam int RANK_W  = $clog2(HASH_WIDTH);

    hll_state_t state;
    hll_state_t state_next;
    logic       alive;
    logic       flush_second;
    logic       accept;

    logic                  s1_valid;
    logic [LAYER_W-1:0]    s1_layer;
    logic [HASH_WIDTH-1:0] s1_hash;
    logic                  s2_valid;
    logic [LAYER_W-1:0]    s2_layer;
    logic [HASH_WIDTH-1:0] s2_hash;
    logic [RANK_W-1:0]     s2_rank;
    logic                  s2_layer_ok;

    logic [NUM_LAYERS-1:0][HASH_WIDTH-1:0] work;
    logic [CNT_WIDTH-1:0]                  epoch_items;

    // alive keeps in_ready low while reset is held and for the edge that releases it.
    assign in_ready    = alive && (state == ACCUM) && !snap_req;
    assign accept      = in_valid && in_ready;
    assign s2_layer_ok = {1'b0, s2_layer} < (LAYER_W + 1)'(NUM_LAYERS);

    hll_tz_encode #(
        .HASH_WIDTH(HASH_WIDTH)
    ) u_tz_encode (
        .hash(s2_hash),
        .rank(s2_rank)
    );

    // State register; flush_second marks the second FLUSH cycle, after which the pipeline is empty.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ACCUM;
            alive        <= 1'b0;
            flush_second <= 1'b0;
        end else begin
            state        <= state_next;
            alive        <= 1'b1;
            flush_second <= (state == FLUSH) && !flush_second;
        end
    end

    // Next-state logic: a level snap_req in ACCUM starts the flush/publish sequence.
    always_comb begin
        state_next = state;
        case (state)
            ACCUM:   if (snap_req) state_next = FLUSH;
            FLUSH:   if (flush_second) state_next = PUBLISH;
            PUBLISH: state_next = ACCUM;
            default: state_next = ACCUM;
        endcase
    end

    // Two-stage token pipeline: S1 captures the accepted token, S2 feeds the rank encoder.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_layer <= '0;
            s1_hash  <= '0;
            s2_valid <= 1'b0;
            s2_layer <= '0;
            s2_hash  <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_layer <= in_layer;
                s1_hash  <= in_hash;
            end
            s2_valid <= s1_valid;
            s2_layer <= s1_layer;
            s2_hash  <= s1_hash;
        end
    end

    // Fold S2 into the working set, and on PUBLISH freeze it to the outputs and clear the epoch.
    // PUBLISH is only reached with both stages empty, so it never races a fold or drop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            work            <= '0;
            epoch_items     <= '0;
            layer_registers <= '0;
            item_count      <= '0;
            epoch           <= '0;
            drop_count      <= '0;
            regs_valid      <= 1'b0;
            snap_ack        <= 1'b0;
        end else begin
            regs_valid <= (state == PUBLISH);
            snap_ack   <= (state == PUBLISH);
            if (state == PUBLISH) begin
                layer_registers <= work;
                item_count      <= epoch_items;
                epoch           <= epoch + 16'd1;
                work            <= '0;
                epoch_items     <= '0;
            end else if (s2_valid) begin
                if (s2_layer_ok) begin
                    work[s2_layer] <= work[s2_layer] | (HASH_WIDTH'(1) << s2_rank);
                    if (epoch_items != '1) begin
                        epoch_items <= epoch_items + CNT_WIDTH'(1);
                    end
                end else if (drop_count != '1) begin
                    drop_count <= drop_count + CNT_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_hll_layer_accumulator.sv
// Directed bench for hll_layer_accumulator with six layers so that layer 7 is out of range.
module tb_hll_layer_accumulator;

    localparam int NL  = 6;
    localparam int HW  = 64;
    localparam int CW  = 32;
    localparam int LWB = 3;

    logic                  clk;
    logic                  reset_n;
    logic                  in_valid;
    logic                  in_ready;
    logic [LWB-1:0]        in_layer;
    logic [HW-1:0]         in_hash;
    logic                  snap_req;
    logic                  snap_ack;
    logic [NL-1:0][HW-1:0] layer_registers;
    logic                  regs_valid;
    logic [15:0]           epoch;
    logic [CW-1:0]         item_count;
    logic [CW-1:0]         drop_count;

    int total = 0;
    int bad   = 0;

    logic [NL-1:0][HW-1:0] exp_regs;

    hll_layer_accumulator #(
        .NUM_LAYERS(NL),
        .HASH_WIDTH(HW),
        .CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_layer(in_layer),
        .in_hash(in_hash),
        .snap_req(snap_req),
        .snap_ack(snap_ack),
        .layer_registers(layer_registers),
        .regs_valid(regs_valid),
        .epoch(epoch),
        .item_count(item_count),
        .drop_count(drop_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%h expected=0x%h", tag, got, expv);
        end
    endtask

    // Drives one cycle of inputs just after the rising edge and returns at the falling edge.
    task automatic applyStimulus(input logic v, input logic [LWB-1:0] layer,
                                 input logic [HW-1:0] hash, input logic snap);
        @(posedge clk);
        #1;
        in_valid = v;
        in_layer = layer;
        in_hash  = hash;
        snap_req = snap;
        @(negedge clk);
    endtask

    task automatic checkLayers(input string tag, input logic [NL-1:0][HW-1:0] expv);
        for (int i = 0; i < NL; i++) begin
            checkOutput($sformatf("%s_L%0d", tag, i), layer_registers[i], expv[i]);
        end
    endtask

    // Cycles T..T+3 of a snapshot: request at T, optionally held through T+3, no accept, no pulse.
    task automatic runFlush(input string tag, input logic v, input logic [LWB-1:0] layer,
                            input logic [HW-1:0] hash, input logic hold);
        applyStimulus(v, layer, hash, 1'b1);
        checkOutput({tag, "_ready_T"}, in_ready, 0);
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(v, layer, hash, hold);
            checkOutput($sformatf("%s_ready_T%0d", tag, k), in_ready, 0);
            checkOutput($sformatf("%s_rv_T%0d", tag, k), regs_valid, 0);
        end
    endtask

    initial begin
        in_valid = 1'b0;
        in_layer = '0;
        in_hash  = '0;
        snap_req = 1'b0;
        reset_n  = 1'b0;

        // Reset held for three cycles.
        repeat (3) applyStimulus(0, 0, 0, 0);
        checkLayers("rst_regs", '0);
        checkOutput("rst_regs_valid", regs_valid, 0);
        checkOutput("rst_snap_ack", snap_ack, 0);
        checkOutput("rst_epoch", epoch, 0);
        checkOutput("rst_items", item_count, 0);
        checkOutput("rst_drops", drop_count, 0);
        checkOutput("rst_ready", in_ready, 0);
        reset_n = 1'b1;
        #1;
        checkOutput("rst_ready_release", in_ready, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("rst_ready_next", in_ready, 1);

        // Fold three hashes into layer 2: bits 0, 3 and 63 (zero hash).
        applyStimulus(1, 2, 64'h1, 0);
        checkOutput("fold_accept", in_ready, 1);
        applyStimulus(1, 2, 64'h8, 0);
        applyStimulus(1, 2, 64'h0, 0);
        runFlush("fold", 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        exp_regs    = '0;
        exp_regs[2] = 64'h8000_0000_0000_0009;
        checkOutput("fold_rv_T4", regs_valid, 1);
        checkOutput("fold_ack_T4", snap_ack, 1);
        checkLayers("fold", exp_regs);
        checkOutput("fold_items", item_count, 3);
        checkOutput("fold_epoch", epoch, 1);
        checkOutput("fold_ready_T4", in_ready, 1);
        applyStimulus(0, 0, 0, 0);
        checkOutput("fold_rv_T5", regs_valid, 0);
        checkOutput("fold_ack_T5", snap_ack, 0);
        checkOutput("fold_hold_L2", layer_registers[2], 64'h8000_0000_0000_0009);

        // Layer 7 is dropped; layer 0 token folds into the next epoch.
        applyStimulus(1, 7, 64'h10, 0);
        applyStimulus(1, 0, 64'h4, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("drop_count", drop_count, 1);
        checkOutput("drop_hold_L2", layer_registers[2], 64'h8000_0000_0000_0009);
        checkOutput("drop_hold_epoch", epoch, 1);
        runFlush("drop", 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        exp_regs    = '0;
        exp_regs[0] = 64'h4;
        checkOutput("drop_rv_T4", regs_valid, 1);
        checkLayers("drop", exp_regs);
        checkOutput("drop_items", item_count, 1);
        checkOutput("drop_epoch", epoch, 2);
        checkOutput("drop_count_kept", drop_count, 1);

        // Token held valid across a snapshot is only taken at T+4 and lands in the next epoch.
        runFlush("cont", 1, 1, 64'h2, 1);
        applyStimulus(1, 1, 64'h2, 0);
        checkOutput("cont_ready_T4", in_ready, 1);
        checkOutput("cont_rv_T4", regs_valid, 1);
        checkLayers("cont", '0);
        checkOutput("cont_items", item_count, 0);
        checkOutput("cont_epoch", epoch, 3);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        runFlush("cont2", 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        exp_regs    = '0;
        exp_regs[1] = 64'h2;
        checkOutput("cont2_rv_T4", regs_valid, 1);
        checkLayers("cont2", exp_regs);
        checkOutput("cont2_items", item_count, 1);
        checkOutput("cont2_epoch", epoch, 4);

        // Reset during FLUSH discards everything and no publish pulse follows.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, LWB'(i), 64'h1, 0);
        end
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        reset_n = 1'b0;
        #1;
        checkLayers("mid_rst", '0);
        checkOutput("mid_rst_epoch", epoch, 0);
        checkOutput("mid_rst_items", item_count, 0);
        checkOutput("mid_rst_drops", drop_count, 0);
        checkOutput("mid_rst_ready", in_ready, 0);
        repeat (2) applyStimulus(0, 0, 0, 0);
        reset_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            applyStimulus(0, 0, 0, 0);
            checkOutput($sformatf("mid_rst_rv_%0d", k), regs_valid, 0);
        end
        checkOutput("mid_rst_epoch_after", epoch, 0);

        // Two back-to-back empty snapshots with snap_req held through T+4.
        runFlush("empty", 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("empty_rv_T4", regs_valid, 1);
        checkOutput("empty_epoch1", epoch, 1);
        checkOutput("empty_ready_T4", in_ready, 0);
        for (int k = 5; k <= 7; k++) begin
            applyStimulus(0, 0, 0, 0);
            checkOutput($sformatf("empty_rv_T%0d", k), regs_valid, 0);
        end
        applyStimulus(0, 0, 0, 0);
        checkOutput("empty_rv_T8", regs_valid, 1);
        checkOutput("empty_ack_T8", snap_ack, 1);
        checkLayers("empty2", '0);
        checkOutput("empty_items", item_count, 0);
        checkOutput("empty_epoch2", epoch, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
